// File: rtl/dram_wr_rd_ctrl.sv
// Button-started DRAM macro test sequencer: serial address, data word, write pulse, optional read-back.
// Define UART_TX_EN to dump the captured read word as two 8N1 bytes on uart_txd.
`timescale 1ns/1ps
module dram_wr_rd_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int WR_PULSE = 4,
  parameter int RD_PULSE = 8,
  parameter int SA_PULSE = 3,
  parameter int BAUD_DIV = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IO_EN_button,
  input  logic [16:1] DRAM16_data,
  input  logic        SW2,
  input  logic        SW3,
  input  logic        SW4,
  input  logic        SW5,
  input  logic        SW6,
  input  logic        SW7,
  input  logic        SW8,
  input  logic        SW9,
  input  logic        SW10,
  input  logic        SW11,
  input  logic        SW12,
  output logic        RD_DONE_LED,
  output logic        WT_DONE_LED,
  output logic [2:0]  PC_data,
  output logic [1:0]  PC_D_IN,
  output logic [1:0]  PC_R_AD,
  output logic [1:0]  LIM_SEL,
  output logic        ADD_IN,
  output logic        ADD_VALID_IN,
  output logic [16:1] D_IN,
  output logic        DATA_VALID_IN,
  output logic [16:1] LIM_IN,
  output logic        clk_out,
  output logic        WRI_EN,
  output logic [16:1] R_AD,
  output logic        DE_ADD3,
  output logic        RD_EN,
  output logic        VSAEN,
  output logic        REF_WWL,
  output logic        uart_txd
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ASHIFT  = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_READ    = 3'd4;
  localparam logic [2:0] S_CAPTURE = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd7;

  localparam logic [15:0] WR_LAST  = 16'(WR_PULSE - 1);
  localparam logic [15:0] RD_LAST  = 16'(RD_PULSE - 1);
  localparam logic [15:0] SA_FIRST = 16'(RD_PULSE - SA_PULSE);
  localparam logic [15:0] CD_LAST  = 16'(CLK_DIV - 1);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [15:0] addr;
  logic [15:0] pattern;
  logic [2:0]  btn_sync;
  logic [10:0] sw_s1;
  logic [10:0] sw_s2;
  logic [15:0] cd_cnt;
  logic        start;
  logic        add_vld_d;
  logic        add_bit_d;
  logic        data_vld_d;
  logic        wri_d;
  logic        rd_d;
  logic        vsa_d;

`ifdef UART_TX_EN
  localparam logic [2:0]  S_TX      = 3'd6;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  logic [19:0] tx_sh;
  logic [4:0]  tx_bit;
  logic [15:0] baud_cnt;
  logic        txd_q;
  logic        tx_done;
`endif

  // Button and switches are asynchronous; the button idles high, so its sync chain resets high.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync <= 3'b111;
      sw_s1    <= '0;
      sw_s2    <= '0;
    end else begin
      btn_sync <= {btn_sync[1:0], IO_EN_button};
      sw_s1    <= {SW12, SW11, SW10, SW9, SW8, SW7, SW6, SW5, SW4, SW3, SW2};
      sw_s2    <= sw_s1;
    end
  end

  assign PC_data = sw_s2[2:0];
  assign PC_D_IN = sw_s2[4:3];
  assign PC_R_AD = sw_s2[6:5];
  assign LIM_SEL = sw_s2[8:7];

  assign start = btn_sync[2] & ~btn_sync[1] & ((state == S_IDLE) | (state == S_DONE));

`ifdef UART_TX_EN
  // Frame is {stop, lo, start, stop, hi, start}, shifted out from bit 0.
  assign tx_done = (state == S_TX) && (baud_cnt == BAUD_LAST) && (tx_bit == 5'd19);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sh    <= '1;
      tx_bit   <= '0;
      baud_cnt <= '0;
      txd_q    <= 1'b1;
    end else begin
      txd_q <= (state == S_TX) ? tx_sh[0] : 1'b1;
      if (state == S_CAPTURE) begin
        tx_sh    <= {1'b1, DRAM16_data[8:1], 1'b0, 1'b1, DRAM16_data[16:9], 1'b0};
        tx_bit   <= '0;
        baud_cnt <= '0;
      end else if (state == S_TX) begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt <= '0;
          tx_bit   <= tx_bit + 5'd1;
          tx_sh    <= {1'b1, tx_sh[19:1]};
        end else begin
          baud_cnt <= baud_cnt + 16'd1;
        end
      end
    end
  end

  assign uart_txd = txd_q;
`else
  // Without the UART the read word has no path off-chip; only RD_DONE_LED reports the read.
  logic unused;
  assign unused   = &{1'b0, DRAM16_data, 32'(BAUD_DIV)};
  assign uart_txd = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr    <= '0;
      pattern <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_ASHIFT;
            cnt     <= '0;
            pattern <= sw_s2[9] ? addr : 16'h5AA5;
          end
        end
        S_ASHIFT: begin
          if (cnt == 16'd15) begin
            state <= S_DATA;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DATA: begin
          state <= S_WRITE;
          cnt   <= '0;
        end
        S_WRITE: begin
          if (cnt == WR_LAST) begin
            cnt <= '0;
            if (sw_s2[10]) begin
              state <= S_READ;
            end else begin
              state <= S_DONE;
              addr  <= addr + 16'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_READ: begin
          if (cnt == RD_LAST) begin
            state <= S_CAPTURE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_CAPTURE: begin
`ifdef UART_TX_EN
          state <= S_TX;
`else
          state <= S_DONE;
          addr  <= addr + 16'd1;
`endif
        end
`ifdef UART_TX_EN
        S_TX: begin
          if (tx_done) begin
            state <= S_DONE;
            addr  <= addr + 16'd1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign add_vld_d  = (state == S_ASHIFT);
  assign add_bit_d  = add_vld_d & addr[4'd15 - cnt[3:0]];
  assign data_vld_d = (state == S_DATA);
  assign wri_d      = (state == S_WRITE);
  assign rd_d       = (state == S_READ);
  assign vsa_d      = rd_d && (cnt >= SA_FIRST);

  // All macro pins are registered one cycle behind the state decode, so pulse widths equal state dwell.
  always_ff @(posedge clk) begin
    if (rst) begin
      ADD_VALID_IN  <= 1'b0;
      ADD_IN        <= 1'b0;
      DATA_VALID_IN <= 1'b0;
      WRI_EN        <= 1'b0;
      REF_WWL       <= 1'b0;
      RD_EN         <= 1'b0;
      DE_ADD3       <= 1'b0;
      VSAEN         <= 1'b0;
      D_IN          <= '0;
      LIM_IN        <= '0;
      R_AD          <= '0;
      WT_DONE_LED   <= 1'b0;
      RD_DONE_LED   <= 1'b0;
    end else begin
      ADD_VALID_IN  <= add_vld_d;
      ADD_IN        <= add_bit_d;
      DATA_VALID_IN <= data_vld_d;
      WRI_EN        <= wri_d;
      REF_WWL       <= wri_d;
      RD_EN         <= rd_d;
      DE_ADD3       <= rd_d;
      VSAEN         <= vsa_d;
      if (data_vld_d) begin
        D_IN   <= pattern;
        LIM_IN <= pattern;
      end
      if (rd_d) begin
        R_AD <= addr;
      end
      if (start) begin
        WT_DONE_LED <= 1'b0;
        RD_DONE_LED <= 1'b0;
      end else begin
        if (WRI_EN && !wri_d) begin
          WT_DONE_LED <= 1'b1;
        end
        if (state == S_CAPTURE) begin
          RD_DONE_LED <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cd_cnt  <= '0;
      clk_out <= 1'b0;
    end else if (cd_cnt == CD_LAST) begin
      cd_cnt  <= '0;
      clk_out <= ~clk_out;
    end else begin
      cd_cnt <= cd_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dram_wr_rd_ctrl.sv
// Randomized bench for dram_wr_rd_ctrl against a per-transaction timeline model.
`timescale 1ns/1ps
module tb_dram_wr_rd_ctrl;

  localparam int WR_PULSE  = 4;
  localparam int RD_PULSE  = 8;
  localparam int SA_PULSE  = 3;
  localparam int BAUD_DIV  = 868;
  localparam int TRACE_LEN = 40;
  // Button low is first sampled on edge 1; address shifting is visible 3 cycles later.
  localparam int ASH_START = 4;
  localparam int DSTART    = ASH_START + 16;
  localparam int WSTART    = DSTART + 1;
  localparam int WEND      = WSTART + WR_PULSE - 1;
  localparam int RSTART    = WEND + 1;
  localparam int REND      = RSTART + RD_PULSE - 1;
`ifdef UART_TX_EN
  localparam int N_RAND = 2;
`else
  localparam int N_RAND = 12;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        IO_EN_button = 1'b1;
  logic [16:1] DRAM16_data = '0;
  logic        SW2 = 0, SW3 = 0, SW4 = 0, SW5 = 0, SW6 = 0, SW7 = 0, SW8 = 0;
  logic        SW9 = 0, SW10 = 0, SW11 = 0, SW12 = 0;
  logic        RD_DONE_LED, WT_DONE_LED, ADD_IN, ADD_VALID_IN, DATA_VALID_IN;
  logic        clk_out, WRI_EN, DE_ADD3, RD_EN, VSAEN, REF_WWL, uart_txd;
  logic [2:0]  PC_data;
  logic [1:0]  PC_D_IN, PC_R_AD, LIM_SEL;
  logic [16:1] D_IN, LIM_IN, R_AD;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_addr;

  always #5 clk = ~clk;

  dram_wr_rd_ctrl #(
    .CLK_DIV(4), .WR_PULSE(WR_PULSE), .RD_PULSE(RD_PULSE), .SA_PULSE(SA_PULSE), .BAUD_DIV(BAUD_DIV)
  ) dut (
    .clk(clk), .rst(rst), .IO_EN_button(IO_EN_button), .DRAM16_data(DRAM16_data),
    .SW2(SW2), .SW3(SW3), .SW4(SW4), .SW5(SW5), .SW6(SW6), .SW7(SW7), .SW8(SW8),
    .SW9(SW9), .SW10(SW10), .SW11(SW11), .SW12(SW12),
    .RD_DONE_LED(RD_DONE_LED), .WT_DONE_LED(WT_DONE_LED), .PC_data(PC_data),
    .PC_D_IN(PC_D_IN), .PC_R_AD(PC_R_AD), .LIM_SEL(LIM_SEL), .ADD_IN(ADD_IN),
    .ADD_VALID_IN(ADD_VALID_IN), .D_IN(D_IN), .DATA_VALID_IN(DATA_VALID_IN),
    .LIM_IN(LIM_IN), .clk_out(clk_out), .WRI_EN(WRI_EN), .R_AD(R_AD),
    .DE_ADD3(DE_ADD3), .RD_EN(RD_EN), .VSAEN(VSAEN), .REF_WWL(REF_WWL),
    .uart_txd(uart_txd)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mask(input int first, input int len);
    if (len <= 0) return '0;
    return ((64'd1 << len) - 64'd1) << first;
  endfunction

`ifdef UART_TX_EN
  task automatic uart_rx(output logic [7:0] b, output logic ok);
    int n;
    n  = 0;
    ok = 1'b1;
    b  = '0;
    while (uart_txd !== 1'b0 && n < 4 * BAUD_DIV) begin
      @(negedge clk);
      n++;
    end
    if (uart_txd !== 1'b0) ok = 1'b0;
    repeat (BAUD_DIV / 2) @(negedge clk);
    if (uart_txd !== 1'b0) ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      repeat (BAUD_DIV) @(negedge clk);
      b[k] = uart_txd;
    end
    repeat (BAUD_DIV) @(negedge clk);
    if (uart_txd !== 1'b1) ok = 1'b0;
  endtask
`endif

  // One button-started transaction; pins are traced per cycle and compared against the expected timeline.
  task automatic run_txn(input logic sw11, input logic sw12, input logic [15:0] rdata,
                         input int width, input int extra_at, input logic [8:0] sw_misc);
    logic [63:0] av, ab, dv, we, ww, re, de, vs, wl, rl;
    logic [15:0] pat, din_d, rad_r, bits;
    logic [63:0] win;
    av = '0; ab = '0; dv = '0; we = '0; ww = '0; re = '0; de = '0; vs = '0; wl = '0; rl = '0;
    din_d = '0; rad_r = '0; bits = '0;
    SW11 = sw11;
    SW12 = sw12;
    DRAM16_data = rdata;
    {SW10, SW9, SW8, SW7, SW6, SW5, SW4, SW3, SW2} = sw_misc;
    repeat (4) @(negedge clk);
    pat = sw11 ? m_addr : 16'h5AA5;
    IO_EN_button = 1'b0;
    for (int i = 1; i <= TRACE_LEN; i++) begin
      @(posedge clk);
      @(negedge clk);
      av[i] = ADD_VALID_IN;  ab[i] = ADD_IN;   dv[i] = DATA_VALID_IN;
      we[i] = WRI_EN;        ww[i] = REF_WWL;  re[i] = RD_EN;
      de[i] = DE_ADD3;       vs[i] = VSAEN;    wl[i] = WT_DONE_LED;  rl[i] = RD_DONE_LED;
      if (i == DSTART) din_d = D_IN;
      if (i == RSTART) rad_r = R_AD;
      if (i == width) IO_EN_button = 1'b1;
      if (extra_at > 0 && i == extra_at) IO_EN_button = 1'b0;
      if (extra_at > 0 && i == extra_at + 2) IO_EN_button = 1'b1;
    end
    for (int k = 0; k < 16; k++) bits[15 - k] = ab[ASH_START + k];
    win = mask(3, TRACE_LEN - 2);
    check_val("add_valid", av, mask(ASH_START, 16));
    check_val("add_bits", bits, m_addr);
    check_val("data_valid", dv, mask(DSTART, 1));
    check_val("d_in", din_d, pat);
    check_val("wri_en", we, mask(WSTART, WR_PULSE));
    check_val("ref_wwl", ww, mask(WSTART, WR_PULSE));
    check_val("wt_led", wl & win, mask(WEND + 1, TRACE_LEN - WEND));
    check_val("rd_en", re, sw12 ? mask(RSTART, RD_PULSE) : 64'd0);
    check_val("de_add3", de, sw12 ? mask(RSTART, RD_PULSE) : 64'd0);
    check_val("vsaen", vs, sw12 ? mask(REND - SA_PULSE + 1, SA_PULSE) : 64'd0);
    check_val("rd_led", rl & win, sw12 ? mask(REND + 1, TRACE_LEN - REND) : 64'd0);
    if (sw12) check_val("r_ad", rad_r, m_addr);
    check_val("d_in_hold", D_IN, pat);
    check_val("lim_in", LIM_IN, pat);
    check_val("pc_pins", {LIM_SEL, PC_R_AD, PC_D_IN, PC_data}, sw_misc);
`ifdef UART_TX_EN
    if (sw12) begin
      logic [7:0] b;
      logic       ok;
      uart_rx(b, ok);
      check_val("uart_frame_hi", ok, 1);
      check_val("uart_byte_hi", b, rdata[15:8]);
      uart_rx(b, ok);
      check_val("uart_frame_lo", ok, 1);
      check_val("uart_byte_lo", b, rdata[7:0]);
      repeat (BAUD_DIV) @(negedge clk);
    end
`endif
    m_addr = m_addr + 16'd1;
  endtask

  initial begin
    time t1, t2;
    logic prev;
    m_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ctrl", {RD_DONE_LED, WT_DONE_LED, PC_data, PC_D_IN, PC_R_AD, LIM_SEL,
                           ADD_IN, ADD_VALID_IN, DATA_VALID_IN, clk_out, WRI_EN,
                           DE_ADD3, RD_EN, VSAEN, REF_WWL}, 64'd0);
    check_val("rst_buses", {D_IN, LIM_IN, R_AD}, 64'd0);
    check_val("rst_uart", uart_txd, 1);
    rst = 1'b0;

    t1 = 0;
    t2 = 0;
    prev = clk_out;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (clk_out && !prev) begin
        if (t1 == 0) t1 = $time;
        else if (t2 == 0) t2 = $time;
      end
      prev = clk_out;
    end
    check_val("clk_out_period", (t1 != 0 && t2 != 0) ? 64'(t2 - t1) : 64'd0, 80);

    {SW10, SW9, SW8, SW7, SW6, SW5, SW4, SW3, SW2} = 9'h1FF;
    @(posedge clk);
    @(negedge clk);
    check_val("sw_one_cycle", PC_data, 0);
    @(posedge clk);
    @(negedge clk);
    check_val("pc_data", PC_data, 3'b111);
    check_val("pc_d_in", PC_D_IN, 2'b11);
    check_val("pc_r_ad", PC_R_AD, 2'b11);
    check_val("lim_sel", LIM_SEL, 2'b11);

    run_txn(1'b0, 1'b0, 16'h0000, 2, 0, 9'h1FF);
    run_txn(1'b1, 1'b0, 16'h0000, 2, 0, 9'h000);
    run_txn(1'b0, 1'b1, 16'hA5A5, 2, 0, 9'h155);
    run_txn(1'b1, 1'b1, 16'h3C96, 3, 8, 9'h0AA);

    // Abort a transaction in the middle of the write pulse.
    SW11 = 1'b0;
    SW12 = 1'b0;
    repeat (4) @(negedge clk);
    IO_EN_button = 1'b0;
    for (int i = 1; i <= WSTART + 1; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 2) IO_EN_button = 1'b1;
    end
    check_val("wri_before_rst", WRI_EN, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("wri_after_rst", {WRI_EN, REF_WWL, WT_DONE_LED}, 0);
    check_val("d_in_after_rst", D_IN, 0);
    rst = 1'b0;
    m_addr = '0;

    for (int t = 0; t < N_RAND; t++) begin
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
              int'($urandom_range(2, 4)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 14)) : 0,
              9'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
